gate_test_mem_server: RTL and testbench

Command responder on the processor side of the gate-tester link. Holds the 16-byte test-vector/result memory, services write commands (fill memory from UART receive bytes, then pulse `rx_done`) and read commands (stream memory bytes out on `tx_byte`, then pulse `tx_done`). It is the other end of the `command` / `start_address` / `end_address` / `tx_byte` / `rx_done` / `tx_done` interface driven by the verification controller.

---
 rtl/gate_test_mem_server_if.sv | 43 ++++
 rtl/gate_test_mem_server.sv | 132 +++++++++++++
 tb/tb_gate_test_mem_server.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_test_mem_server_if.sv
// Command/byte bus between the verification controller and the
// gate-test memory server.
interface gate_test_mem_server_if;
  logic [7:0]  command;
  logic [15:0] start_address;
  logic [15:0] end_address;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_done;
  logic        rx_done;
  logic        busy;
  logic [7:0]  drop_count;

  modport master (
    output command,
    output start_address,
    output end_address,
    output rx_valid,
    output rx_data,
    input  tx_byte,
    input  tx_valid,
    input  tx_done,
    input  rx_done,
    input  busy,
    input  drop_count
  );

  modport slave (
    input  command,
    input  start_address,
    input  end_address,
    input  rx_valid,
    input  rx_data,
    output tx_byte,
    output tx_valid,
    output tx_done,
    output rx_done,
    output busy,
    output drop_count
  );
endinterface

// File: rtl/gate_test_mem_server.sv
// Processor-side responder of the gate-tester link: owns the test
// vector/result memory and services read and write transfers.
module gate_test_mem_server #(
  parameter int unsigned DEPTH     = 16,
  parameter logic [7:0]  CMD_READ  = 8'h00,
  parameter logic [7:0]  CMD_WRITE = 8'h01
) (
  input logic clk,
  input logic rst,
  gate_test_mem_server_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_WDONE = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_RDONE = 3'd4;

  logic [2:0]    state;
  logic [2:0]    state_nx;
  logic [7:0]    last_cmd;
  logic [15:0]   ptr;
  logic [15:0]   end_q;
  logic [7:0]    mem [DEPTH];

  logic [7:0]    tx_byte_q;
  logic          tx_valid_q;
  logic          tx_done_q;
  logic          rx_done_q;
  logic          busy_q;
  logic [7:0]    drop_q;

  logic          accept;
  logic          at_end;
  logic          empty;
  logic          wr_en;
  logic [AW-1:0] idx;

  assign idx    = ptr[AW-1:0];
  assign accept = (state == S_IDLE) &&
                  (bus.command != last_cmd);
  assign at_end = (ptr == end_q);
  assign empty  = (bus.end_address < bus.start_address);
  assign wr_en  = (state == S_WRITE) && bus.rx_valid;

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (bus.command == CMD_WRITE)
            state_nx = empty ? S_WDONE : S_WRITE;
          else if (bus.command == CMD_READ)
            state_nx = empty ? S_RDONE : S_READ;
        end
      end
      S_WRITE: begin
        if (bus.rx_valid && at_end)
          state_nx = S_WDONE;
      end
      S_WDONE: state_nx = S_IDLE;
      S_READ: begin
        if (at_end)
          state_nx = S_RDONE;
      end
      S_RDONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Unknown command codes still update last_cmd so they are not re-seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      last_cmd <= 8'hFF;
      ptr      <= '0;
      end_q    <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        last_cmd <= bus.command;
        ptr      <= bus.start_address;
        end_q    <= bus.end_address;
      end else if (wr_en && !at_end) begin
        ptr <= ptr + 16'd1;
      end else if (state == S_READ && !at_end) begin
        ptr <= ptr + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++)
        mem[i] <= '0;
    end else if (wr_en) begin
      mem[idx] <= bus.rx_data;
    end
  end

  // rx_done coincides with WDONE; tx_done trails RDONE by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_byte_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_done_q  <= 1'b0;
      rx_done_q  <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= '0;
    end else begin
      tx_valid_q <= (state == S_READ);
      tx_done_q  <= (state == S_RDONE);
      rx_done_q  <= (state_nx == S_WDONE);
      busy_q     <= (state_nx != S_IDLE);
      if (state == S_READ)
        tx_byte_q <= mem[idx];
      if (bus.rx_valid && state != S_WRITE &&
          drop_q != 8'hFF)
        drop_q <= drop_q + 8'd1;
    end
  end

  assign bus.tx_byte    = tx_byte_q;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.tx_done    = tx_done_q;
  assign bus.rx_done    = rx_done_q;
  assign bus.busy       = busy_q;
  assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_gate_test_mem_server.sv
// Scoreboard bench for gate_test_mem_server: read bytes are predicted
// from a memory model and checked as tx_valid strobes arrive.
module tb_gate_test_mem_server;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gate_test_mem_server_if bus();

  gate_test_mem_server #(
    .DEPTH(16),
    .CMD_READ(8'h00),
    .CMD_WRITE(8'h01)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model [16];
  logic [7:0] exp_v;
  logic prev_txd = 1'b0;
  logic prev_rxd = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.tx_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected got %02h required none",
                   bus.tx_byte);
        end else begin
          exp_v = exp_q.pop_front();
          if (bus.tx_byte !== exp_v) begin
            errors++;
            $display("FAIL tx_byte got %02h required %02h",
                     bus.tx_byte, exp_v);
          end
        end
      end
      if (bus.tx_done || bus.rx_done) begin
        checks++;
        if ((bus.tx_done && bus.rx_done) ||
            (bus.tx_done && prev_txd) ||
            (bus.rx_done && prev_rxd)) begin
          errors++;
          $display("FAIL done_pulse got tx=%0b rx=%0b prev=%0b%0b required single",
                   bus.tx_done, bus.rx_done, prev_txd, prev_rxd);
        end
      end
    end
    prev_txd = bus.tx_done;
    prev_rxd = bus.rx_done;
  end

  task automatic check_read_timing(input int len);
    logic ev, ed, eb;
    for (int j = 0; j <= len + 3; j++) begin
      @(negedge clk);
      ev = (j >= 2 && j <= len + 1);
      ed = (j == len + 2);
      eb = (j >= 1 && j <= len + 1);
      checks++;
      if (bus.tx_valid !== ev || bus.tx_done !== ed ||
          bus.busy !== eb) begin
        errors++;
        $display("FAIL read_timing cyc %0d got v=%0b d=%0b b=%0b required v=%0b d=%0b b=%0b",
                 j, bus.tx_valid, bus.tx_done, bus.busy, ev, ed, eb);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL read_missing got %0d left required 0",
               exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic read_xfer(input logic [15:0] s,
                           input logic [15:0] e);
    int len;
    @(posedge clk); #1;
    len = (e >= s) ? int'(e - s) + 1 : 0;
    for (int a = 0; a < len; a++)
      exp_q.push_back(model[(int'(s) + a) % 16]);
    bus.start_address = s;
    bus.end_address   = e;
    bus.command       = 8'h00;
    check_read_timing(len);
  endtask

  task automatic write_xfer(input logic [15:0] s,
                            input logic [15:0] e,
                            input logic [7:0] d [4],
                            input int n);
    @(posedge clk); #1;
    bus.start_address = s;
    bus.end_address   = e;
    bus.command       = 8'h01;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL wr_busy_n got %0b required 0", bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.rx_done !== (n == 0)) begin
      errors++;
      $display("FAIL wr_enter got b=%0b d=%0b required b=1 d=%0b",
               bus.busy, bus.rx_done, (n == 0));
    end
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = d[i];
      model[(int'(s) + i) % 16] = d[i];
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.rx_done !== (i == n - 1)) begin
        errors++;
        $display("FAIL rx_done byte %0d got %0b required %0b",
                 i, bus.rx_done, (i == n - 1));
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.rx_done !== 1'b0) begin
      errors++;
      $display("FAIL wr_exit got b=%0b d=%0b required 0 0",
               bus.busy, bus.rx_done);
    end
  endtask

  task automatic test_reset;
    bus.command       = 8'h00;
    bus.start_address = 16'd8;
    bus.end_address   = 16'd8;
    bus.rx_valid      = 1'b0;
    bus.rx_data       = 8'h00;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.tx_byte !== 8'h00 || bus.tx_valid !== 1'b0 ||
        bus.tx_done !== 1'b0 || bus.rx_done !== 1'b0 ||
        bus.busy !== 1'b0 || bus.drop_count !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got %02h %0b%0b%0b%0b %02h required 00 0000 00",
               bus.tx_byte, bus.tx_valid, bus.tx_done,
               bus.rx_done, bus.busy, bus.drop_count);
    end
    @(posedge clk); #1;
    exp_q.push_back(model[8]);
    rst = 1'b0;
    check_read_timing(1);
    checks++;
    if (bus.drop_count !== 8'h00) begin
      errors++;
      $display("FAIL reset_drop got %0d required 0", bus.drop_count);
    end
  endtask

  task automatic test_write_read;
    logic [7:0] d [4];
    d = '{8'hB4, 8'h00, 8'h00, 8'h00};
    write_xfer(16'd8, 16'd8, d, 1);
    read_xfer(16'd8, 16'd8);
    checks++;
    if (bus.drop_count !== 8'h00) begin
      errors++;
      $display("FAIL wr_drop got %0d required 0", bus.drop_count);
    end
  endtask

  task automatic test_wrap_and_drop;
    logic [7:0] d [4];
    d = '{8'h11, 8'h22, 8'h33, 8'h44};
    write_xfer(16'd14, 16'd17, d, 4);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.rx_done !== 1'b0) begin
        errors++;
        $display("FAIL hold_cmd got b=%0b d=%0b required 0 0",
                 bus.busy, bus.rx_done);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus.rx_valid = 1'b1;
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (bus.drop_count !== 8'd3) begin
      errors++;
      $display("FAIL drop_3 got %0d required 3", bus.drop_count);
    end
    @(posedge clk); #1;
    bus.rx_valid = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.drop_count !== 8'd255) begin
      errors++;
      $display("FAIL drop_sat got %0d required 255", bus.drop_count);
    end
    read_xfer(16'd14, 16'd17);
  endtask

  task automatic test_empty_range;
    logic [7:0] d [4];
    d = '{8'hEE, 8'hEE, 8'hEE, 8'hEE};
    write_xfer(16'd5, 16'd4, d, 0);
    read_xfer(16'd5, 16'd4);
  endtask

  task automatic test_reset_mid_read;
    @(posedge clk); #1;
    bus.command = 8'h02;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL other_code got busy=%0b required 0", bus.busy);
      end
    end
    @(posedge clk); #1;
    for (int a = 0; a < 16; a++) exp_q.push_back(model[a]);
    bus.start_address = 16'd0;
    bus.end_address   = 16'd15;
    bus.command       = 8'h00;
    repeat (5) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0 ||
        exp_q.size() != 13) begin
      errors++;
      $display("FAIL mid_reset got v=%0b b=%0b left=%0d required 0 0 13",
               bus.tx_valid, bus.busy, exp_q.size());
    end
    exp_q.delete();
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    bus.start_address = 16'd0;
    bus.end_address   = 16'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.tx_done !== 1'b0 || bus.drop_count !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_hold got d=%0b drop=%0d required 0 0",
               bus.tx_done, bus.drop_count);
    end
    @(posedge clk); #1;
    exp_q.push_back(model[0]);
    rst = 1'b0;
    check_read_timing(1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_wrap_and_drop();
    test_empty_range();
    test_reset_mid_read();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
